// File: rtl/uart_dec_rx_pkg.sv
// Shared constants and state encodings for the decimal-ASCII UART blocks
// (receiver and transmitter sides).
package uart_dec_rx_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_WAIT, P_ACCUM, P_DISCARD} parse_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/uart_dec_rx_if.sv
// Serial input and parsed-value outputs of the decimal UART receiver.
interface uart_dec_rx_if;
  logic        uart_rxd;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_err;

  modport master (output uart_rxd, input data_out, data_valid, data_err);
  modport slave  (input uart_rxd, output data_out, data_valid, data_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 byte receiver: synchronizes uart_rxd, samples at bit centers and
// reports each byte with a one-cycle rx_done plus a stop-bit frame_err flag.
module uart_rx
  import uart_dec_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             rxd_s;

  assign rxd_s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], uart_rxd};
    prev_d  = rxd_s;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (prev_q && !rxd_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          // A start bit that is already high again at mid-bit was a glitch.
          state_d = rxd_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          done_d  = 1'b1;
          ferr_d  = !rxd_s;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= RX_IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte   = shift_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_dec_rx.sv
// Decimal line receiver: turns CR-terminated lines of 1..MAX_DIGITS ASCII
// digits into a 16-bit value with valid / error strobes.
module uart_dec_rx
  import uart_dec_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int MAX_DIGITS = 5
) (
  input logic          sys_clk,
  input logic          sys_rst,
  uart_dec_rx_if.slave bus
);

  localparam int DCNT_W = $clog2(MAX_DIGITS + 1);

  logic [7:0] rx_byte;
  logic       rx_done;
  logic       frame_err;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_rx (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .uart_rxd  (bus.uart_rxd),
    .rx_byte   (rx_byte),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  // acc*10 + digit, wide enough that an overflowing digit is still visible.
  function automatic logic [20:0] mul10_add(input logic [16:0] acc, input logic [7:0] b);
    logic [20:0] a;
    a = {4'b0, acc};
    return (a << 3) + (a << 1) + 21'(b - ASCII_0);
  endfunction

  parse_state_t      pstate_q, pstate_d;
  logic [16:0]       acc_q, acc_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [15:0]       data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              data_err_q, data_err_d;
  logic [20:0]       next_acc;

  always_comb begin
    pstate_d     = pstate_q;
    acc_d        = acc_q;
    dcnt_d       = dcnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    data_err_d   = 1'b0;
    next_acc     = mul10_add(acc_q, rx_byte);
    if (rx_done) begin
      if (pstate_q == P_DISCARD) begin
        if (rx_byte == ASCII_CR) begin
          data_err_d = 1'b1;
          acc_d      = '0;
          dcnt_d     = '0;
          pstate_d   = P_WAIT;
        end
      end else if (frame_err) begin
        pstate_d = P_DISCARD;
      end else if (is_digit(rx_byte)) begin
        if ((dcnt_q >= DCNT_W'(MAX_DIGITS)) || (next_acc > 21'd65535)) begin
          pstate_d = P_DISCARD;
        end else begin
          acc_d    = next_acc[16:0];
          dcnt_d   = dcnt_q + 1'b1;
          pstate_d = P_ACCUM;
        end
      end else if (rx_byte == ASCII_CR) begin
        // An empty line (CR while still in WAIT) is silently accepted.
        if (pstate_q == P_ACCUM) begin
          data_out_d   = acc_q[15:0];
          data_valid_d = 1'b1;
          acc_d        = '0;
          dcnt_d       = '0;
          pstate_d     = P_WAIT;
        end
      end else if (rx_byte != ASCII_LF) begin
        pstate_d = P_DISCARD;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pstate_q     <= P_WAIT;
      acc_q        <= '0;
      dcnt_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      data_err_q   <= 1'b0;
    end else begin
      pstate_q     <= pstate_d;
      acc_q        <= acc_d;
      dcnt_q       <= dcnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      data_err_q   <= data_err_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.data_err   = data_err_q;

endmodule

// File: tb/tb_uart_dec_rx.sv
// Bench for uart_dec_rx: table of lines with hand-derived results, corner
// sequences (glitch, reset mid-line) and random lines against a line model.
module tb_uart_dec_rx;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int BIT       = CLK_FREQ / BAUD_RATE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_dec_rx_if bus ();

  uart_dec_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .MAX_DIGITS (5)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;
  int n_rxd   = 0;

  always @(negedge clk) begin
    if (bus.data_valid) n_valid++;
    if (bus.data_err) n_err++;
    if (bus.data_valid && bus.data_err) n_both++;
    if (dut.rx_done) n_rxd++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    bus.uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    bus.uart_rxd = stop_v;
    repeat (BIT) @(negedge clk);
    if (!stop_v) begin
      bus.uart_rxd = 1'b1;
      repeat (BIT) @(negedge clk);
    end
  endtask

  logic [7:0] line_q[$];
  int         bad_idx;

  task automatic apply_line(input string name, input int exp_v, input int exp_e,
                            input logic [15:0] exp_d);
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    for (int i = 0; i < line_q.size(); i++) send_byte(line_q[i], (i == bad_idx) ? 1'b0 : 1'b1);
    repeat (24) @(negedge clk);
    check({name, " valid"}, n_valid - v0, exp_v);
    check({name, " err"}, n_err - e0, exp_e);
    check({name, " data"}, int'(bus.data_out), int'(exp_d));
  endtask

  typedef struct {
    string       txt;
    int          bad;
    int          exp_v;
    int          exp_e;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[12];

  // Reference: evaluate a whole line (LFs removed) with plain integer math.
  logic [15:0] model_data;
  task automatic model_line(output int ev, output int ee);
    int n, val;
    bit bad;
    n = 0; val = 0; bad = 0;
    for (int i = 0; i < line_q.size() - 1; i++) begin
      if (line_q[i] == 8'h0A) continue;
      if (line_q[i] >= 8'h30 && line_q[i] <= 8'h39) begin
        n++;
        val = val * 10 + int'(line_q[i] - 8'h30);
      end else begin
        bad = 1;
      end
    end
    ev = 0; ee = 0;
    if (bad || n > 5 || val > 65535) ee = 1;
    else if (n > 0) begin
      ev = 1;
      model_data = 16'(val);
    end
  endtask

  initial begin
    string s;
    int v0, e0, r0, ev, ee;
    bus.uart_rxd = 1'b1;

    vecs[0]  = '{"12345\015",     -1, 1, 0, 16'd12345};
    vecs[1]  = '{"65535\015\012", -1, 1, 0, 16'd65535};
    vecs[2]  = '{"7\015",         -1, 1, 0, 16'd7};
    vecs[3]  = '{"65536\015",     -1, 0, 1, 16'd7};
    vecs[4]  = '{"123456\015",    -1, 0, 1, 16'd7};
    vecs[5]  = '{"1a2\015",       -1, 0, 1, 16'd7};
    vecs[6]  = '{"12\015",         0, 0, 1, 16'd7};
    vecs[7]  = '{"42\015",        -1, 1, 0, 16'd42};
    vecs[8]  = '{"\015",          -1, 0, 0, 16'd42};
    vecs[9]  = '{"00017\015",     -1, 1, 0, 16'd17};
    vecs[10] = '{"\012\0125\012\015", -1, 1, 0, 16'd5};
    vecs[11] = '{"3/\015",        -1, 0, 1, 16'd5};

    repeat (3) @(negedge clk);
    check("reset data_out", int'(bus.data_out), 0);
    check("reset valid", int'(bus.data_valid), 0);
    check("reset err", int'(bus.data_err), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      s = vecs[k].txt;
      line_q.delete();
      for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
      bad_idx = vecs[k].bad;
      apply_line($sformatf("vec%0d", k), vecs[k].exp_v, vecs[k].exp_e, vecs[k].exp_d);
    end

    // Quarter-bit low pulse on an idle line must not start a frame.
    v0 = n_valid; e0 = n_err; r0 = n_rxd;
    bus.uart_rxd = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    bus.uart_rxd = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("glitch rx_done", n_rxd - r0, 0);
    check("glitch events", (n_valid - v0) + (n_err - e0), 0);

    // Reset during the third digit of "999\r", then a fresh line.
    v0 = n_valid; e0 = n_err;
    send_byte(8'h39, 1'b1);
    send_byte(8'h39, 1'b1);
    bus.uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    bus.uart_rxd = 1'b1;
    repeat (BIT) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midline reset data_out", int'(bus.data_out), 0);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    check("midline reset events", (n_valid - v0) + (n_err - e0), 0);
    line_q.delete();
    line_q.push_back(8'h38);
    line_q.push_back(8'h0D);
    bad_idx = -1;
    apply_line("after reset", 1, 0, 16'd8);
    model_data = 16'd8;

    for (int k = 0; k < 14; k++) begin
      int len, r;
      line_q.delete();
      len = $urandom_range(0, 7);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 19);
        if (r < 16) line_q.push_back(8'h30 + 8'($urandom_range(0, 9)));
        else if (r < 18) line_q.push_back(8'h0A);
        else if (r == 18) line_q.push_back(8'h2F);
        else line_q.push_back(8'h3A);
      end
      line_q.push_back(8'h0D);
      bad_idx = -1;
      model_line(ev, ee);
      apply_line($sformatf("rand%0d", k), ev, ee, model_data);
    end

    check("valid and err together", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_dec_rx.md
# uart_dec_rx

Receive-side counterpart of the decimal-ASCII UART reporter. Deserializes 8N1 UART frames on `uart_rxd`, parses a line of 1–5 ASCII decimal digits terminated by CR (0x0D), and presents the value as a 16-bit unsigned word with a one-cycle valid strobe. Host-to-FPGA commands and parameters (gain, channel select, thresholds) enter the design through this block.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate; `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` (integer division).
- `MAX_DIGITS`, default 5: maximum number of digits accepted per line.

- `sys_clk` in 1: system clock; all logic runs on its rising edge.
- `sys_rst` in 1: asynchronous, active-high reset.
- `uart_rxd` in 1: serial input, idle high, asynchronous to `sys_clk`.
- `data_out` out 16: last successfully parsed value; held until the next successful line.
- `data_valid` out 1: one-cycle pulse when `data_out` is updated.
- `data_err` out 1: one-cycle pulse when a line is rejected.

## Operation
- Byte receiver:
  - `uart_rxd` passes through a 2-flop synchronizer; all decisions use the synchronized value.
  - IDLE -> START on a synchronized high-to-low transition.
  - START: at `CLKS_PER_BIT/2`, if the line is still low, go to DATA; if high, treat as a glitch and return to IDLE.
  - DATA: sample 8 bits at bit centers (every `CLKS_PER_BIT`), LSB first.
  - STOP: sample at the stop-bit center, pulse `rx_done` for one cycle with `rx_byte`, and set `frame_err` if the sample is low. Then return to IDLE.
- Line parser, states WAIT, ACCUM, DISCARD:
  - WAIT/ACCUM, digit 0x30–0x39: `acc = acc*10 + (byte-0x30)`, 17-bit accumulator, `dcnt++`, state = ACCUM.
  - Digit that makes `dcnt > MAX_DIGITS` or `acc > 65535` -> DISCARD.
  - LF (0x0A): ignored in every state.
  - CR in ACCUM: `data_out <= acc[15:0]`, pulse `data_valid`, clear `acc`/`dcnt`, -> WAIT.
  - CR in WAIT (empty line): no pulse, stay in WAIT.
  - CR in DISCARD: pulse `data_err`, clear `acc`/`dcnt`, -> WAIT.
  - Any other byte, or any byte with `frame_err`, in WAIT/ACCUM -> DISCARD. In DISCARD, all bytes except CR are dropped.
- Leading zeros are legal: "00042" = 42, 5 digits.
- `data_valid` and `data_err` are never asserted together.

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `data_err` = 0. Receiver goes to IDLE, parser to WAIT, `acc`/`dcnt` = 0.
- Reset mid-frame or mid-line discards the partial byte or line. After release, the receiver waits for a fresh falling edge.
- Latency:
  - `rx_done` falls 2 (sync) + ~9.5×`CLKS_PER_BIT` cycles after the start edge.
  - `data_valid`/`data_err` are registered, asserted the cycle after `rx_done` for the CR byte.
- Back-to-back frames (stop bit followed immediately by a start bit) must be received without loss. The receiver is back in IDLE half a bit before the stop bit ends.
- Parser handles one byte per `rx_done`; no backpressure, no buffering.

## Structure
- Shared package/header holds:
  - ASCII constants: `ASCII_CR` = 8'h0D, `ASCII_LF` = 8'h0A, `ASCII_0` = 8'h30, `ASCII_9` = 8'h39.
  - Receiver and parser state encodings.
  - The same constants are used by the transmitter side.
- One sub-module, `uart_rx`:
  - Ports: `sys_clk`, `sys_rst`, `uart_rxd`, `rx_byte[7:0]`, `rx_done`, `frame_err`; parameters `CLK_FREQ`, `BAUD_RATE`.
  - Mirrors the existing byte transmitter.
- Parser FSM and accumulator live in `uart_dec_rx`. `acc*10` is implemented as `(acc<<3)+(acc<<1)`.

## Test plan
- "12345\r" at 115200 baud, 50 MHz clock -> one `data_valid` pulse, `data_out` = 12345, `data_err` stays 0.
- "65535\r\n" then "7\r" -> `data_out` = 65535, then 7. LF causes no event.
- "65536\r", then "123456\r" -> two `data_err` pulses, `data_out` unchanged, no `data_valid`.
- "1a2\r", and "12\r" sent with one stop bit forced low -> `data_err` each. A following "42\r" gives `data_out` = 42.
- Bare "\r", and a 1/4-bit low glitch on an idle line -> no pulses, no byte received.
- Assert `sys_rst` during the 3rd digit of "999\r", release, send "8\r" -> no pulse for the aborted line, `data_out` = 8.
